// File: rtl/ppu_ap_issue_queue.sv
// Command FIFO + credit-limited issuer feeding the PPU ap-control wrapper; push-to-ap_start is 2 edges.
// Producer sees in_ready low only when the FIFO is full; issue stalls while credits are exhausted.
module ppu_ap_issue_queue #(
    parameter int WORD            = 32,
    parameter int OP_SIZE         = 3,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                       ap_clk,
    input  logic                                       ap_rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [WORD-1:0]                            in_op1,
    input  logic [WORD-1:0]                            in_op2,
    input  logic [OP_SIZE-1:0]                         in_op,
    output logic                                       ap_start,
    output logic [WORD-1:0]                            ppu_in1,
    output logic [WORD-1:0]                            ppu_in2,
    output logic [OP_SIZE-1:0]                         ppu_op,
    input  logic                                       ap_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
    output logic                                       idle,
    output logic                                       err_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [WORD-1:0]    op1;
        logic [WORD-1:0]    op2;
        logic [OP_SIZE-1:0] op;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outstanding;
    logic          r_ap_start;
    cmd_t          r_ppu;
    logic          r_err;

    logic          w_push;
    logic          w_issue;
    logic          w_in_ready;

    // Both decisions look only at registered state, so a pop never frees a slot
    // for a push, nor a returning credit an issue, within the same cycle.
    assign w_in_ready = (r_count != CW'(DEPTH));
    assign w_push     = in_valid && w_in_ready;
    assign w_issue    = (r_count != '0) && (r_outstanding < OW'(MAX_OUTSTANDING));

    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{op1: in_op1, op2: in_op2, op: in_op};
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_ap_start <= 1'b0;
            r_ppu      <= '0;
        end else begin
            r_ap_start <= w_issue;
            if (w_issue) begin
                r_ppu <= r_mem[r_rd_ptr];
            end
        end
    end

    // A done with nothing in flight is a protocol error; the count saturates at 0.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else if (w_issue && !ap_done) begin
            r_outstanding <= r_outstanding + OW'(1);
        end else if (!w_issue && ap_done) begin
            if (r_outstanding == '0) begin
                r_err <= 1'b1;
            end else begin
                r_outstanding <= r_outstanding - OW'(1);
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign ap_start      = r_ap_start;
    assign ppu_in1       = r_ppu.op1;
    assign ppu_in2       = r_ppu.op2;
    assign ppu_op        = r_ppu.op;
    assign outstanding   = r_outstanding;
    assign idle          = (r_count == '0) && (r_outstanding == '0) && !r_ap_start;
    assign err_underflow = r_err;

endmodule

// File: doc/ppu_ap_issue_queue.md
Name: ppu_ap_issue_queue

Overview:
- Upstream command stage for the PPU ap-control wrapper.
- Buffers (operand1, operand2, opcode) commands from a valid/ready producer in a small FIFO, and issues them one per cycle as single-cycle ap_start pulses with registered operands.
- Limits in-flight operations with a credit counter that is returned on each ap_done pulse, so a finite downstream result sink is never overrun.

Parameters:
- WORD, 32, operand/result width; equals the PPU WORD.
- OP_SIZE, 3, opcode width; equals the PPU OP_SIZE.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 8, maximum issued-but-not-done operations; at least 1.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer command valid.
- in_ready  out  1  queue can accept a command.
- in_op1  in  WORD  operand 1.
- in_op2  in  WORD  operand 2.
- in_op  in  OP_SIZE  opcode.
- ap_start  out  1  single-cycle issue pulse to the PPU wrapper.
- ppu_in1  out  WORD  registered operand 1.
- ppu_in2  out  WORD  registered operand 2.
- ppu_op  out  OP_SIZE  registered opcode.
- ap_done  in  1  one-cycle result-valid pulse from the PPU wrapper; returns one credit.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  current in-flight count.
- idle  out  1  FIFO empty, outstanding==0 and ap_start==0.
- err_underflow  out  1  sticky: ap_done was received while outstanding==0.

Behaviour:
- Reset (async assert, sync release):
  - FIFO count, read pointer and write pointer go to 0.
  - ap_start=0; ppu_in1, ppu_in2 and ppu_op go to 0; outstanding=0; err_underflow=0.
  - in_ready=1 and idle=1 after reset.
  - Reset mid-operation discards all queued entries and credits. The PPU shares ap_rst, so no stale ap_done is expected.
- FIFO:
  - in_ready = (count != DEPTH). It is derived from registered count only; there is no same-cycle bypass from a pop.
  - Push occurs when in_valid && in_ready: the entry is written at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
  - Pop happens only through issue. rd_ptr increments, wrapping modulo DEPTH.
  - Push and pop in the same cycle: count is unchanged and both pointers advance.
- Issue rule, evaluated each cycle:
  - can_issue = (count != 0) && (outstanding < MAX_OUTSTANDING).
  - If can_issue, on the next edge the head entry is registered into ppu_in1, ppu_in2 and ppu_op, ap_start=1 for that one cycle, and the head is popped.
  - Otherwise ap_start=0 on the next edge and ppu_in1, ppu_in2 and ppu_op hold their last values.
  - Back-to-back issue (ap_start high on consecutive cycles) is legal while entries and credits remain.
- Latency: a command pushed at edge k into an empty queue with credits available produces ap_start=1 in the cycle following edge k+1. Minimum latency is 2 edges.
- Credits (outstanding):
  - Issue only: outstanding +1.
  - Valid ap_done only: outstanding -1.
  - Issue and ap_done in the same cycle: outstanding unchanged.
  - At outstanding==MAX_OUTSTANDING, issue stalls. A concurrent ap_done does not allow issue in the same cycle, because can_issue uses the registered count; issue resumes on the next cycle.
- Underflow: ap_done with outstanding==0 (and no issue in the same cycle) leaves outstanding at 0 and sets err_underflow, which stays set until reset.
- Data ordering: commands are issued strictly in push order; nothing is reordered or dropped.

Test Plan:
- Reset, then push (op1=0x40000000, op2=0x48000000, op=0) at edge 1 -> ap_start=1 only in the cycle after edge 2 with ppu_in1=0x40000000, ppu_in2=0x48000000, ppu_op=0; outstanding=1; idle=0; then ap_done -> outstanding=0, idle=1.
- Hold ap_done low and push 10 distinct commands with in_valid held high, MAX_OUTSTANDING=8, DEPTH=4 -> exactly 8 ap_start pulses in push order; the remaining 2 stay queued with in_ready still 1 (count=2); each later ap_done releases exactly one more issue.
- Fill the FIFO with credits at 0 (outstanding preloaded to 8) -> in_ready=0 after 4 pushes; a 5th in_valid is not accepted; after one ap_done, one issue occurs and in_ready returns to 1 on the following cycle.
- Pulse ap_done while outstanding==0 -> err_underflow=1 and sticky, outstanding stays 0; it clears only on ap_rst.
- Assert ap_rst asynchronously mid-stream with 3 queued and 2 outstanding -> all outputs reset immediately, without waiting for a clock edge; no ap_start after release until a new push.
- Push and ap_done coincide with issue every cycle for 16 cycles -> outstanding constant, pointers wrap past DEPTH, output order matches input order.
